// File: rtl/soc_uart_pkg.sv
// soc_uart_pkg: shared definitions for the AXI-Lite UART receiver.
//   - register byte offsets and their addr[3:2] indices
//   - STATUS bit positions and the STATUS layout struct
//   - AXI response codes
//   - RX FSM state enum
//   - baud_div(): oversample divider (clocks per 1/16 bit, truncated)
`timescale 1ns/1ps
package soc_uart_pkg;

  localparam logic [3:0] OFF_RXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  localparam logic [1:0] IDX_RXDATA = OFF_RXDATA[3:2];
  localparam logic [1:0] IDX_STATUS = OFF_STATUS[3:2];
  localparam logic [1:0] IDX_CTRL   = OFF_CTRL[3:2];
  localparam logic [1:0] IDX_RSVD   = OFF_RSVD[3:2];

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVR       = 2;
  localparam int ST_FERR      = 3;
  localparam int RX_EMPTY_BIT = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Field order gives not_empty at bit 0 ... ferr at bit 3.
  typedef struct packed {
    logic ferr;
    logic ovr;
    logic full;
    logic not_empty;
  } status_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receiver.
//   clk_i   : clock
//   rst_ni  : async active-low reset (already synchronized)
//   rxd_i   : raw serial line, idle high
//   byte_o  : received byte, valid with valid_o
//   valid_o : one-cycle pulse, good stop bit
//   ferr_o  : one-cycle pulse, stop bit sampled low (byte discarded)
`timescale 1ns/1ps
module uart_rx_core
  import soc_uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       ferr_o
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic fall;

  // Line idles high, so the synchronizer resets to 1 to avoid a fake start edge.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) {rxd_meta_q, rxd_sync_q, rxd_prev_q} <= 3'b111;
    else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end

  assign fall = rxd_prev_q & ~rxd_sync_q;

  rx_state_e        state_q;
  logic [DCW-1:0]   div_q;
  logic [3:0]       tick_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             brk_q;
  logic             tick, mid;

  // Divider is held at 0 in IDLE and restarts at the start edge, so the
  // 8th tick of every bit lands near its centre.
  assign tick = (state_q != RX_IDLE) && (div_q == DCW'(DIV - 1));
  assign mid  = tick && (tick_cnt_q == 4'd7);

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= RX_IDLE;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
      byte_o     <= '0;
      valid_o    <= 1'b0;
      ferr_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      ferr_o  <= 1'b0;
      if (state_q == RX_IDLE || tick) div_q <= '0;
      else                            div_q <= div_q + 1'b1;
      if (tick) tick_cnt_q <= tick_cnt_q + 1'b1;
      case (state_q)
        RX_IDLE: begin
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          // After a framing error the line must be seen high before re-arming.
          if (brk_q) begin
            if (rxd_sync_q) brk_q <= 1'b0;
          end else if (fall) begin
            state_q <= RX_START;
          end
        end
        RX_START: if (mid) state_q <= rxd_sync_q ? RX_IDLE : RX_DATA;
        RX_DATA: if (mid) begin
          shift_q   <= {rxd_sync_q, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_q <= RX_STOP;
        end
        RX_STOP: if (mid) begin
          state_q <= RX_IDLE;
          if (rxd_sync_q) begin
            byte_o  <= shift_q;
            valid_o <= 1'b1;
          end else begin
            ferr_o <= 1'b1;
            brk_q  <= 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end

endmodule

// File: rtl/axi_uart_rx.sv
// axi_uart_rx: UART receiver with FIFO behind an AXI-Lite slave.
//   clk_50mhz, rst_btn (async, active-high, synchronized internally)
//   uart_rxd          : serial input, 8N1, idle high
//   S_AW*/S_W*/S_B*   : AXI-Lite write channels
//   S_AR*/S_R*        : AXI-Lite read channels
//   irq               : IRQ_EN & (NOT_EMPTY | OVR | FERR), registered
// Registers (addr[3:2]): 0x0 RXDATA (pop on read), 0x4 STATUS (W1C OVR/FERR),
// 0x8 CTRL.IRQ_EN; 0xC or nonzero addr[AW-1:4] -> SLVERR.
// FIFO_DEPTH must be a power of two >= 2.
`timescale 1ns/1ps
module axi_uart_rx
  import soc_uart_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk_50mhz,
  input  logic            rst_btn,
  input  logic            uart_rxd,
  input  logic [AW-1:0]   S_AWADDR,
  input  logic            S_AWVALID,
  output logic            S_AWREADY,
  input  logic [DW-1:0]   S_WDATA,
  input  logic [DW/8-1:0] S_WSTRB,
  input  logic            S_WVALID,
  output logic            S_WREADY,
  output logic [1:0]      S_BRESP,
  output logic            S_BVALID,
  input  logic            S_BREADY,
  input  logic [AW-1:0]   S_ARADDR,
  input  logic            S_ARVALID,
  output logic            S_ARREADY,
  output logic [DW-1:0]   S_RDATA,
  output logic [1:0]      S_RRESP,
  output logic            S_RVALID,
  input  logic            S_RREADY,
  output logic            irq
);

  localparam int PW = $clog2(FIFO_DEPTH);

  // Async assert, sync deassert.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk_50mhz or posedge rst_btn)
    if (rst_btn) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_core (
    .clk_i  (clk_50mhz),
    .rst_ni (rst_n),
    .rxd_i  (uart_rxd),
    .byte_o (rx_byte),
    .valid_o(rx_valid),
    .ferr_o (rx_ferr)
  );

  logic                       alive_q, aw_got_q, w_got_q, bvalid_q, rvalid_q;
  logic                       irq_en_q, ovr_q, ferr_q, irq_q;
  logic [1:0]                 bresp_q, rresp_q;
  logic [DW-1:0]              rdata_q, wdata_q;
  logic [AW-1:0]              awaddr_q;
  logic [DW/8-1:0]            wstrb_q;
  logic [PW:0]                wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH-1:0][7:0] mem_q;

  logic [PW:0]     level;
  logic            empty, full, push, pop, ovr_set;
  logic            aw_hs, w_hs, ar_hs, wr_fire, ar_bad, wr_bad, clr_ovr, clr_ferr;
  logic            ovr_d, ferr_d, irq_d;
  logic [1:0]      ar_sel, wr_sel;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data, rd_word;
  logic [DW/8-1:0] wr_strb;
  status_t         status;
  logic            unused_bits;

  // FIFO
  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == (PW+1)'(FIFO_DEPTH));
  assign ar_hs   = S_ARVALID & S_ARREADY;
  assign ar_sel  = S_ARADDR[3:2];
  assign ar_bad  = (S_ARADDR[AW-1:4] != '0) || (ar_sel == IDX_RSVD);
  // Pop at the AR handshake so RDATA is frozen against later arrivals.
  assign pop     = ar_hs & ~ar_bad & (ar_sel == IDX_RXDATA) & ~empty;
  // A simultaneous pop frees the slot, so a full FIFO still takes the byte.
  assign push    = rx_valid & (~full | pop);
  assign ovr_set = rx_valid & full & ~pop;

  // Write path: AW and W may arrive in either order; fire once both are held.
  assign aw_hs   = S_AWVALID & S_AWREADY;
  assign w_hs    = S_WVALID & S_WREADY;
  assign wr_fire = (aw_got_q | aw_hs) & (w_got_q | w_hs);
  assign wr_addr = aw_hs ? S_AWADDR : awaddr_q;
  assign wr_data = w_hs ? S_WDATA : wdata_q;
  assign wr_strb = w_hs ? S_WSTRB : wstrb_q;
  assign wr_sel  = wr_addr[3:2];
  assign wr_bad  = (wr_addr[AW-1:4] != '0) || (wr_sel == IDX_RSVD);

  assign clr_ovr  = wr_fire & ~wr_bad & (wr_sel == IDX_STATUS) & wr_strb[0] & wr_data[ST_OVR];
  assign clr_ferr = wr_fire & ~wr_bad & (wr_sel == IDX_STATUS) & wr_strb[0] & wr_data[ST_FERR];
  // Set beats clear when both land in the same cycle.
  assign ovr_d  = ovr_set | (ovr_q & ~clr_ovr);
  assign ferr_d = rx_ferr | (ferr_q & ~clr_ferr);
  assign irq_d  = irq_en_q & (~empty | ovr_q | ferr_q);

  assign status = '{ferr: ferr_q, ovr: ovr_q, full: full, not_empty: ~empty};

  always_comb begin
    rd_word = '0;
    if (!ar_bad) begin
      case (ar_sel)
        IDX_RXDATA: begin
          if (empty) rd_word[RX_EMPTY_BIT] = 1'b1;
          else       rd_word[7:0] = mem_q[rd_ptr_q[PW-1:0]];
        end
        IDX_STATUS: rd_word[3:0] = status;
        IDX_CTRL:   rd_word[0]   = irq_en_q;
        default:    rd_word      = '0;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz)
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= rx_byte;

  always_ff @(posedge clk_50mhz or negedge rst_n)
    if (!rst_n) begin
      alive_q  <= 1'b0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      irq_q    <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      wdata_q  <= '0;
      awaddr_q <= '0;
      wstrb_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      alive_q <= 1'b1;
      if (bvalid_q && S_BREADY) bvalid_q <= 1'b0;
      if (wr_fire) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_bad ? RESP_SLVERR : RESP_OKAY;
        if (!wr_bad && wr_sel == IDX_CTRL && wr_strb[0]) irq_en_q <= wr_data[0];
      end else begin
        if (aw_hs) begin
          aw_got_q <= 1'b1;
          awaddr_q <= S_AWADDR;
        end
        if (w_hs) begin
          w_got_q <= 1'b1;
          wdata_q <= S_WDATA;
          wstrb_q <= S_WSTRB;
        end
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= ar_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && S_RREADY) begin
        rvalid_q <= 1'b0;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      irq_q  <= irq_d;
    end

  // Ready terms are gated by alive_q so they read 0 while in reset.
  assign S_AWREADY = alive_q & ~aw_got_q & ~bvalid_q;
  assign S_WREADY  = alive_q & ~w_got_q & ~bvalid_q;
  assign S_ARREADY = alive_q & ~rvalid_q;
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign S_RVALID  = rvalid_q;
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;
  assign irq       = irq_q;

  assign unused_bits = ^{S_AWADDR[1:0], S_ARADDR[1:0], wr_data, wr_strb};

endmodule

// File: tb/tb_axi_uart_rx.sv
// Self-checking bench for axi_uart_rx: bytes sent on uart_rxd are modelled
// in a queue mirroring the receive FIFO and compared on RXDATA reads.
`timescale 1ns/1ps
module tb_axi_uart_rx;
  import soc_uart_pkg::*;

  localparam int BIT_CLKS = 432;
  localparam int DEPTH    = 4;

  logic        clk_50mhz = 1'b0, rst_btn = 1'b1, uart_rxd = 1'b1;
  logic [31:0] S_AWADDR = '0, S_WDATA = '0, S_ARADDR = '0;
  logic [3:0]  S_WSTRB = '0;
  logic        S_AWVALID = 0, S_WVALID = 0, S_BREADY = 0, S_ARVALID = 0, S_RREADY = 0;
  logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, irq;
  logic [1:0]  S_BRESP, S_RRESP;
  logic [31:0] S_RDATA;

  always #10 clk_50mhz = ~clk_50mhz;

  axi_uart_rx dut (
    .clk_50mhz(clk_50mhz), .rst_btn(rst_btn), .uart_rxd(uart_rxd),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .irq(irq)
  );

  int         n_chk = 0, n_fail = 0;
  logic [7:0] sb[$];
  logic       exp_ovr = 1'b0, exp_ferr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk_50mhz);
    #1;
  endtask

  // Drive one 8N1 frame; update the FIFO model with what the DUT should do.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk_50mhz); #1;
    uart_rxd = 1'b0; clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i]; clks(BIT_CLKS);
    end
    uart_rxd = stop; clks(BIT_CLKS);
    uart_rxd = 1'b1; clks(20);
    if (!stop)                  exp_ferr = 1'b1;
    else if (sb.size() < DEPTH) sb.push_back(b);
    else                        exp_ovr = 1'b1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t;
    @(negedge clk_50mhz);
    S_ARADDR = addr; S_ARVALID = 1'b1;
    t = 0;
    while (!S_ARREADY && t < 200) begin @(negedge clk_50mhz); t++; end
    chk("arready", S_ARREADY, 1);
    @(posedge clk_50mhz); #1;
    S_ARVALID = 1'b0;
    t = 0;
    while (!S_RVALID && t < 200) begin @(negedge clk_50mhz); t++; end
    chk("rvalid", S_RVALID, 1);
    data = S_RDATA; resp = S_RRESP;
    S_RREADY = 1'b1;
    @(posedge clk_50mhz); #1;
    S_RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int t;
    @(negedge clk_50mhz);
    S_AWADDR = addr; S_AWVALID = 1'b1;
    S_WDATA = data; S_WSTRB = strb; S_WVALID = 1'b1;
    t = 0;
    while (!(S_AWREADY && S_WREADY) && t < 200) begin @(negedge clk_50mhz); t++; end
    chk("aw_w_ready", {S_AWREADY, S_WREADY}, 2'b11);
    @(posedge clk_50mhz); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    t = 0;
    while (!S_BVALID && t < 200) begin @(negedge clk_50mhz); t++; end
    chk("bvalid", S_BVALID, 1);
    resp = S_BRESP;
    S_BREADY = 1'b1;
    @(posedge clk_50mhz); #1;
    S_BREADY = 1'b0;
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] d, e;
    logic [1:0]  r;
    if (sb.size() > 0) e = {24'h0, sb.pop_front()};
    else               e = 32'h100;
    axi_read(32'h0, d, r);
    chk(tag, d, e);
    chk({tag, "_rresp"}, r, RESP_OKAY);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d, e;
    logic [1:0]  r;
    e = {28'h0, exp_ferr, exp_ovr, sb.size() == DEPTH, sb.size() != 0};
    axi_read(32'h4, d, r);
    chk(tag, d, e);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          hi_cnt;

    // Reset state
    clks(5);
    chk("rst_outs", {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID,
                     S_BRESP, S_RRESP, S_RDATA, irq}, 0);
    rst_btn = 1'b0;
    clks(5);
    check_status("status_init");

    // Single byte, then an empty read
    send_byte(8'h48, 1'b1);
    chk("irq_masked", irq, 0);
    check_rx("rx_48");
    check_rx("rx_empty_1");

    // Overflow: five bytes into four entries
    for (int b = 8'h41; b <= 8'h45; b++) send_byte(8'(b), 1'b1);
    check_status("status_ovr_full");
    for (int i = 0; i < 4; i++) check_rx("rx_fifo_order");
    check_rx("rx_empty_2");
    axi_write(32'h4, 32'h4, 4'h0, r);
    check_status("status_w1c_nostrb");
    axi_write(32'h4, 32'h4, 4'h1, r);
    exp_ovr = 1'b0;
    check_status("status_ovr_clr");

    // Framing error with IRQ enabled
    axi_write(32'h8, 32'h1, 4'hF, r);
    axi_read(32'h8, d, r);
    chk("ctrl_rd", d, 32'h1);
    send_byte(8'h3C, 1'b0);
    check_status("status_ferr");
    chk("irq_ferr", irq, 1);
    axi_write(32'h4, 32'h8, 4'hF, r);
    exp_ferr = 1'b0;
    check_status("status_ferr_clr");
    clks(2);
    chk("irq_clr", irq, 0);

    // Short low glitch must be rejected
    uart_rxd = 1'b0; clks(100);
    uart_rxd = 1'b1; clks(600);
    chk("glitch_idle", 32'(dut.u_core.state_q), 32'(RX_IDLE));
    check_status("status_glitch");
    check_rx("rx_empty_glitch");

    // Decode errors
    axi_read(32'hC, d, r);
    chk("rd_0c_data", d, 0);
    chk("rd_0c_resp", r, RESP_SLVERR);
    axi_read(32'h10, d, r);
    chk("rd_10_resp", r, RESP_SLVERR);
    axi_write(32'hC, 32'h1, 4'hF, r);
    chk("wr_0c_resp", r, RESP_SLVERR);

    // AW three cycles ahead of W, B held off by BREADY=0
    @(negedge clk_50mhz);
    chk("aw_idle_ready", S_AWREADY, 1);
    S_AWADDR = 32'h8; S_AWVALID = 1'b1;
    @(posedge clk_50mhz); #1;
    S_AWVALID = 1'b0;
    chk("aw_held", S_AWREADY, 0);
    clks(2);
    chk("bvalid_early", S_BVALID, 0);
    S_WDATA = 32'h0; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    @(posedge clk_50mhz); #1;
    S_WVALID = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_50mhz);
      if (S_BVALID) hi_cnt++;
    end
    chk("bvalid_held", hi_cnt, 6);
    chk("bresp_ok", S_BRESP, RESP_OKAY);
    S_BREADY = 1'b1;
    @(posedge clk_50mhz); #1;
    S_BREADY = 1'b0;
    chk("bvalid_drop", S_BVALID, 0);
    axi_read(32'h8, d, r);
    chk("ctrl_after_split", d, 0);

    // Reset mid-frame with outstanding activity
    axi_write(32'h8, 32'h1, 4'hF, r);
    send_byte(8'h11, 1'b1);
    chk("irq_data", irq, 1);
    uart_rxd = 1'b0; clks(BIT_CLKS);
    uart_rxd = 1'b1; clks(BIT_CLKS);
    @(negedge clk_50mhz);
    S_AWADDR = 32'h8; S_WDATA = 32'h1; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARADDR = 32'h4; S_ARVALID = 1'b1;
    @(posedge clk_50mhz); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    clks(2);
    chk("pre_rst_valids", {S_BVALID, S_RVALID, S_RDATA}, {2'b11, 32'h1});
    rst_btn = 1'b1;
    #2;
    chk("rst_mid_outs", {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID,
                         S_BRESP, S_RRESP, S_RDATA, irq}, 0);
    uart_rxd = 1'b1;
    sb.delete();
    exp_ovr = 1'b0; exp_ferr = 1'b0;
    clks(5);
    rst_btn = 1'b0;
    clks(10);
    axi_read(32'h8, d, r);
    chk("ctrl_after_rst", d, 0);
    send_byte(8'h55, 1'b1);
    check_rx("rx_55_after_rst");
    check_status("status_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_uart_rx.md
AXI_UART_RX -- requirements
Module: axi_uart_rx

Interface
REQ-001 SHALL take parameter AW, default 32, AXI-Lite address width.
REQ-002 SHALL take parameter DW, default 32, AXI-Lite data width.
REQ-003 SHALL take parameter CLK_HZ, default 50_000_000, clock frequency.
REQ-004 SHALL take parameter BAUD, default 115200, line rate.
REQ-005 SHALL take parameter FIFO_DEPTH, default 4, receive FIFO entries, power of two.
REQ-006 SHALL have ports:
- clk_50mhz in 1: clock.
- rst_btn in 1: reset, asynchronous, active-high.
- uart_rxd in 1: serial input, idle high, 8N1.
- S_AWADDR in AW, S_AWVALID in 1, S_AWREADY out 1: write address channel.
- S_WDATA in DW, S_WSTRB in DW/8, S_WVALID in 1, S_WREADY out 1: write data channel.
- S_BRESP out 2, S_BVALID out 1, S_BREADY in 1: write response channel.
- S_ARADDR in AW, S_ARVALID in 1, S_ARREADY out 1: read address channel.
- S_RDATA out DW, S_RRESP out 2, S_RVALID out 1, S_RREADY in 1: read data channel.
- irq out 1: level, high while the FIFO is non-empty or a sticky error is set.

Function
REQ-007 SHALL pass uart_rxd through a 2-flop synchronizer reset to 1; all RX logic SHALL use the synchronized value.
REQ-008 SHALL generate an oversample tick every DIV=CLK_HZ/(BAUD*16) clocks (integer truncation: 27 at defaults, 432 clocks per bit).
REQ-009 SHALL implement the RX FSM: IDLE -> START on a synchronized falling edge; START -> DATA if the line is low at tick 8; otherwise START -> IDLE (glitch rejected); DATA samples 8 bits LSB-first at tick 8 of each bit; DATA -> STOP; STOP samples at tick 8 -> IDLE.
REQ-010 SHALL push the byte into the FIFO when the stop sample is 1; when it is 0 SHALL discard the byte, set FERR, and wait in IDLE for the line to read high before accepting another start.
REQ-011 SHALL, on a push while the FIFO is full and not popped in the same cycle, drop the new byte and set OVR; a push and pop in the same cycle while full SHALL succeed without OVR.
REQ-012 SHALL provide a register map decoded on addr[3:2]:
- 0x0 RXDATA (RO): [7:0] byte, [8] EMPTY; a read pops one entry when non-empty; an empty read returns 0x100 with no pop.
- 0x4 STATUS: [0] NOT_EMPTY, [1] FULL, [2] OVR, [3] FERR; write-1-to-clear on [3:2], only when WSTRB[0]=1.
- 0x8 CTRL (RW): [0] IRQ_EN, reset 0; irq = IRQ_EN & (NOT_EMPTY|OVR|FERR).
- 0xC and any addr[AW-1:4] != 0: RDATA 0, write ignored, RESP SLVERR (2'b10); all other accesses OKAY (2'b00).
REQ-013 SHALL accept AW and W independently, each at most once per transaction; S_BVALID SHALL assert the cycle after both are captured and hold until S_BREADY; no new AW/W is accepted while BVALID is high.
REQ-014 SHALL accept AR only when RVALID is low; S_RVALID SHALL assert the cycle after the AR handshake with registered data and hold stable until S_RREADY.
REQ-015 SHALL pop the FIFO on the AR handshake for RXDATA, so a byte arriving after that handshake does not alter the pending RDATA.
REQ-016 SHALL apply the write-1-to-clear on the W/AW capture cycle; a set and a clear of the same sticky bit in one cycle SHALL leave it set.

Reset
REQ-017 SHALL synchronize rst_btn with a 2-flop chain (asynchronous assert, synchronous deassert) to an internal active-low reset.
REQ-018 SHALL reset all outputs: READY/VALID signals 0, BRESP/RRESP 0, RDATA 0, irq 0.
REQ-019 SHALL reset the FSM to IDLE, the FIFO to empty, OVR/FERR/IRQ_EN to 0, and the baud counter to 0; a frame in flight at reset SHALL be lost.

Structure
REQ-020 SHALL place the register offsets, STATUS bit indices, RESP codes and the RX FSM state enum in the shared package soc_uart_pkg.
REQ-021 SHALL implement the synchronizer, baud tick and FSM in the sub-module uart_rx_core (outputs: byte, valid pulse, ferr pulse); the FIFO and AXI logic SHALL remain in axi_uart_rx.

Verification
REQ-022 SHALL cover: send 0x48 at 115200 baud, read 0x0 -> RDATA 0x048, RRESP 0; then read 0x0 again -> RDATA 0x100.
REQ-023 SHALL cover: send 0x41..0x45 with no reads -> STATUS 0x3|0x4 (OVR set, FULL); reads return 0x41..0x44 in order.
REQ-024 SHALL cover: a frame with the stop bit driven 0 -> FERR=1, FIFO empty; write 0x8 to 0x4 -> FERR=0.
REQ-025 SHALL cover: a 100-clock low glitch on uart_rxd -> no byte pushed, FSM back in IDLE, STATUS 0.
REQ-026 SHALL cover: read 0xC -> RRESP 2'b10, RDATA 0; AW issued 3 cycles before W -> a single BVALID pulse held under S_BREADY=0 backpressure.
REQ-027 SHALL cover: rst_btn asserted mid-frame -> all outputs 0 within 1 cycle; the next clean 0x55 frame is received correctly.
